// File: rtl/alu16_mul_ctrl.sv
// Shift-add sequencer for unsigned 16x16->32 multiply, borrowing the shared
// 16-bit ALU for one add per cycle over 16 RUN cycles.
module alu16_mul_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] op_a,
    input  logic [15:0] op_b,
    output logic        busy,
    output logic        done,
    output logic [31:0] product,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic        alu_b_negate,
    output logic [2:0]  alu_op,
    input  logic [15:0] alu_result,
    input  logic        alu_carry_out
);

    localparam logic [2:0] ADD_OP = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      state_r, state_s;
    logic [15:0] m_r, m_s;
    logic [15:0] phi_r, phi_s;
    logic [15:0] plo_r, plo_s;
    logic [4:0]  cnt_r, cnt_s;
    logic        busy_r, done_r;
    logic [16:0] sum_s;

    // Next-state and datapath update; the 33-bit partial product shifts right each RUN cycle.
    always_comb begin
        state_s = state_r;
        m_s     = m_r;
        phi_s   = phi_r;
        plo_s   = plo_r;
        cnt_s   = cnt_r;
        if (plo_r[0]) begin
            sum_s = {alu_carry_out, alu_result};
        end else begin
            sum_s = {1'b0, phi_r};
        end
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    m_s     = op_a;
                    plo_s   = op_b;
                    phi_s   = 16'd0;
                    cnt_s   = 5'd0;
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                phi_s = sum_s[16:1];
                plo_s = {sum_s[0], plo_r[15:1]};
                cnt_s = cnt_r + 5'd1;
                if (cnt_r == 5'd15) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, operand/product registers and the registered handshake flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            m_r     <= 16'd0;
            phi_r   <= 16'd0;
            plo_r   <= 16'd0;
            cnt_r   <= 5'd0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            m_r     <= m_s;
            phi_r   <= phi_s;
            plo_r   <= plo_s;
            cnt_r   <= cnt_s;
            busy_r  <= (state_s == ST_RUN);
            done_r  <= (state_s == ST_DONE);
        end
    end

    // ALU drive is only non-zero while the ALU is owned (RUN).
    always_comb begin
        alu_b_negate = 1'b0;
        if (busy_r) begin
            alu_a  = phi_r;
            alu_b  = m_r;
            alu_op = ADD_OP;
        end else begin
            alu_a  = 16'd0;
            alu_b  = 16'd0;
            alu_op = 3'd0;
        end
    end

    assign busy    = busy_r;
    assign done    = done_r;
    assign product = {phi_r, plo_r};

endmodule
